pipe_muxn_reg: RTL and testbench
================================

Name: pipe_muxn_reg

Overview:
- Parametrised successor to the team's 2:1 32-bit datapath mux.
- Selects one of NUM WIDTH-bit inputs and registers the result behind a valid/ready handshake with stall and flush.
- Sits in the pipelined CPU datapath as a stage-boundary mux, e.g. for forwarding or writeback select. It replaces a combinational mux followed by a separate pipeline register.

Parameters:
- WIDTH, 32, data width per input.
- NUM, 4, number of inputs (2..16).
- SEL_W, 2, select width. Must satisfy 2**SEL_W >= NUM.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept this cycle
- in_sel  in  SEL_W  input select, sampled with in_valid
- in_data  in  NUM*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- flush  in  1  discard all held words
- out_valid  out  1  registered word valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  registered selected word
- out_err  out  1  held word came from an out-of-range select
- err_cnt  out  8  saturating count of out-of-range selects accepted

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_err=0, err_cnt=0, skid empty. in_ready reads 1 in the first cycle after reset deasserts.
- Accept occurs when in_valid & in_ready. On accept:
  - out_data <= in_data[in_sel*WIDTH +: WIDTH];
  - out_valid <= 1;
  - out_err <= 0.
- Out-of-range select: if in_sel >= NUM at accept, out_data <= 0 and out_err <= 1. err_cnt increments and saturates at 255.
- Latency is 1 cycle from accept to out_valid.
- Without skid buffer: in_ready = ~out_valid | out_ready (combinational).
- If out_ready & out_valid and no accept occurs, out_valid <= 0 next cycle.
- Simultaneous drain and accept: the new word replaces the old one, with no bubble.
- Stall: while out_valid & ~out_ready, out_data and out_err hold stable and in_ready=0.
- Flush:
  - next cycle out_valid=0 and the skid is emptied;
  - flush overrides a same-cycle accept, so the word is dropped and err_cnt is not incremented;
  - out_data keeps its last value;
  - in_ready=1 the cycle after flush.
- Reset mid-transfer: the word is discarded with no output. Reset has priority over flush.
- in_data and in_sel are don't-care when in_valid=0.

Optional Feature:
- Macro: PIPE_MUXN_SKID_EN.
- When defined:
  - adds a one-entry skid buffer holding data and err;
  - in_ready becomes a register: in_ready = ~skid_full;
  - a word accepted while out_valid & ~out_ready goes into the skid;
  - when out_ready is next asserted, the skid moves to the output and in_ready returns to 1 on the following cycle;
  - throughput remains 1 word per cycle;
  - at most 2 words are in flight.
- When undefined: the combinational in_ready described in Behaviour, with one word in flight.
- Port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - localparam ERR_CNT_W = 8;
  - a function clog2 for SEL_W checking;
  - a typedef for the {err, data} payload used by the output register and skid.
- Sub-module muxn_comb is combinational only: NUM-way select with an out-of-range flag, parameters WIDTH/NUM/SEL_W. It is the natural generalisation of the 2:1 mux.
- The handshake, skid and counter logic live in pipe_muxn_reg.

Test Plan:
- Reset, then in_valid=1, in_sel=2, in_data input2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_err=0.
- Stream of 4 words at sel 0,1,2,3 with out_ready held at 1 -> 4 consecutive valid outputs, no bubbles, in_ready constant 1.
- out_ready=0 for 3 cycles while out_valid=1 -> out_data held stable. in_ready=0 without skid; with skid, one extra word is accepted and then in_ready=0. Both words appear in order after out_ready=1.
- NUM=3, in_sel=3 -> out_data=0, out_err=1, err_cnt=1. Repeated 300 times -> err_cnt saturates at 255.
- flush asserted together with an accept while out_valid=1 -> next cycle out_valid=0, skid empty, err_cnt unchanged, in_ready=1.
- reset asserted while the output is stalled -> next cycle out_valid=0, out_data=0, err_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined datapath mux family.
// Holds the error-counter width and a constant clog2 used to check select
// widths at elaboration. The {err, data} payload struct depends on the data
// width, so each block declares it next to its WIDTH parameter.
package pipe_pkg;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Smallest r with 2**r >= value; value <= 1 gives 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage : pipe_pkg

// File: rtl/muxn_comb.sv
// NUM-way combinational select of WIDTH-bit words from a flattened bus.
// Input k occupies data[k*WIDTH +: WIDTH]. A select with no matching input
// drives y to zero and raises oor.
module muxn_comb #(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]     sel,
  input  logic [NUM*WIDTH-1:0] data,
  output logic [WIDTH-1:0]     y,
  output logic                 oor
);

  // Scan every implemented input; an unmatched select falls through to zero.
  always_comb begin
    // NOTE: both outputs get a value before the loop so no path leaves them
    // unassigned, which would otherwise infer a latch.
    y   = '0;
    oor = 1'b1;
    for (int k = 0; k < NUM; k++) begin
      if (sel == SEL_W'(k)) begin
        y   = data[k*WIDTH +: WIDTH];
        oor = 1'b0;
      end
    end
  end

endmodule : muxn_comb

// File: rtl/pipe_muxn_reg.sv
// Stage-boundary N:1 mux with a registered, valid/ready output.
// One word is selected from in_data on accept and presented one cycle later.
// Out-of-range selects produce a zero word flagged by out_err and are counted
// in a saturating err_cnt. flush drops everything held; reset wins over flush.
// Build option: define PIPE_MUXN_SKID_EN to add a one-entry skid buffer,
// which registers in_ready and allows two words in flight.
module pipe_muxn_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } payload_t;

  if (NUM < 2 || NUM > 16 || SEL_W < clog2(NUM)) begin : g_param_check
    $error("pipe_muxn_reg: NUM must be 2..16 and 2**SEL_W >= NUM");
  end

  logic [WIDTH-1:0]     sel_data;
  logic                 sel_oor;
  payload_t             in_pl;
  payload_t             out_q;
  logic                 out_valid_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 take;

  muxn_comb #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .SEL_W (SEL_W)
  ) u_mux (
    .sel  (in_sel),
    .data (in_data),
    .y    (sel_data),
    .oor  (sel_oor)
  );

  assign in_pl = '{err: sel_oor, data: sel_data};

  // A word is really taken only when accepted and not dropped by flush.
  assign take = in_valid & in_ready & ~flush;

  // Count out-of-range words that were really taken, saturating at all-ones.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      err_cnt_q <= '0;
    end else if (take && sel_oor && err_cnt_q != ERR_CNT_MAX) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

`ifdef PIPE_MUXN_SKID_EN

  payload_t skid_q;
  logic     skid_full_q;

  // With the skid, ready depends only on state, which breaks the
  // combinational out_ready -> in_ready path.
  assign in_ready = ~skid_full_q;

  // Output register and skid occupancy: skid drains first, a new word goes to
  // the output when it is free or being drained, otherwise into the skid.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_full_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (skid_full_q) begin
      if (out_ready) begin
        out_q       <= skid_q;
        skid_full_q <= 1'b0;
      end
    end else if (take) begin
      if (~out_valid_q | out_ready) begin
        out_q       <= in_pl;
        out_valid_q <= 1'b1;
      end else begin
        skid_full_q <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Skid payload capture when a word arrives behind a stalled output.
  always_ff @(posedge clock) begin
    // NOTE: the skid payload has no reset; skid_full_q qualifies it, so its
    // contents are never observed before being written.
    if (take && out_valid_q && !out_ready) begin
      skid_q <= in_pl;
    end
  end

`else

  // Ready whenever the output register is empty or being drained this cycle.
  assign in_ready = ~out_valid_q | out_ready;

  // Single output register: load on take, clear valid on drain without refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (take) begin
      out_q       <= in_pl;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_err   = out_q.err;
  assign err_cnt   = err_cnt_q;

endmodule : pipe_muxn_reg

// File: tb/tb_pipe_muxn_reg.sv
// Directed bench for pipe_muxn_reg (NUM=3 so select 3 is out of range).
// A queue holds the words the block should be holding, oldest first; each
// cycle the outputs are compared to the queue head and the word is popped
// when it is drained. Works for both builds of PIPE_MUXN_SKID_EN.
module tb_pipe_muxn_reg;

  localparam int WIDTH = 32;
  localparam int NUM   = 3;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [NUM*WIDTH-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_err;
  logic [7:0]        err_cnt;

  exp_t        q[$];
  exp_t        last_out;
  int unsigned model_cnt;
  bit          model_known;
  int          n_cmp;
  int          n_fail;

  always #5 clock = ~clock;

  pipe_muxn_reg #(
    .WIDTH (WIDTH),
    .NUM   (NUM),
    .SEL_W (SEL_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                     input logic [31:0] w2);
    return {w2, w1, w0};
  endfunction

  function automatic exp_t model_sel(input logic [1:0] s, input logic [95:0] d);
    logic [95:0] sh;
    exp_t        e;
    if (int'(s) < NUM) begin
      sh     = d >> (32 * int'(s));
      e.err  = 1'b0;
      e.data = sh[31:0];
    end else begin
      e.err  = 1'b1;
      e.data = '0;
    end
    return e;
  endfunction

  // One clock: drive inputs, check in_ready, advance the model, check outputs.
  task automatic tick(input bit v, input logic [1:0] s, input logic [95:0] d,
                      input bit ordy, input bit fl, input bit rst);
    bit   exp_rdy;
    bit   acc;
    bit   drn;
    exp_t nw;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
`ifdef PIPE_MUXN_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    if (model_known && !rst) check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy && !fl && !rst;
    drn = (q.size() > 0) && ordy;
    nw  = model_sel(s, d);
    @(posedge clock);
    if (rst) begin
      q.delete();
      last_out    = '0;
      model_cnt   = 0;
      model_known = 1'b1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(nw);
        if (nw.err && model_cnt < 255) model_cnt++;
      end
    end
    if (q.size() > 0) last_out = q[0];
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_err", 64'(out_err), 64'(q[0].err));
    end else begin
      check("held_data", 64'(out_data), 64'(last_out.data));
      check("held_err", 64'(out_err), 64'(last_out.err));
    end
    check("err_cnt", 64'(err_cnt), 64'(model_cnt));
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    model_cnt   = 0;
    model_known = 1'b0;
    last_out    = '0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sel      = '0;
    in_data     = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;

    // Reset, then an idle cycle where in_ready must read 1.
    tick(0, 2'd0, '0, 0, 0, 1);
    tick(0, 2'd0, '0, 0, 0, 1);
    tick(0, 2'd0, '0, 1, 0, 0);

    // First word from input 2.
    tick(1, 2'd2, mk(32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF), 1, 0, 0);
    tick(0, 2'd0, '0, 1, 0, 0);

    // Back-to-back stream at selects 0..3 (3 is out of range).
    for (int i = 0; i < 4; i++) begin
      tick(1, 2'(i), mk(32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                        32'hC000_0000 + 32'(i)), 1, 0, 0);
    end
    tick(0, 2'd0, '0, 1, 0, 0);

    // Stall for three cycles behind a held word, then drain.
    tick(1, 2'd1, mk(32'h0, 32'h5151_5151, 32'h0), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 2'd0, mk(32'h7000_0000 + 32'(i), 32'h0, 32'h0), 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) tick(0, 2'd0, '0, 1, 0, 0);

    // Flush with a same-cycle out-of-range accept: word dropped, count unchanged.
    tick(1, 2'd0, mk(32'hE0E0_E0E0, 32'h0, 32'h0), 0, 0, 0);
    tick(1, 2'd3, mk(32'hF0F0_F0F0, 32'h0, 32'h0), 1, 1, 0);
    tick(0, 2'd0, '0, 0, 0, 0);

    // Flush while stalled (skid full in the skid build).
    tick(1, 2'd1, mk(32'h0, 32'h1234_5678, 32'h0), 0, 0, 0);
    tick(1, 2'd2, mk(32'h0, 32'h0, 32'h8765_4321), 0, 0, 0);
    tick(1, 2'd3, '0, 0, 1, 0);
    tick(0, 2'd0, '0, 1, 0, 0);

    // Out-of-range select 300 times: count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      tick(1, 2'd3, mk($urandom, $urandom, $urandom), 1, 0, 0);
    end
    tick(0, 2'd0, '0, 1, 0, 0);

    // Mixed random traffic with occasional flush.
    for (int i = 0; i < 80; i++) begin
      tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           mk($urandom, $urandom, $urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 0);
    end

    // Reset while the output is stalled.
    tick(0, 2'd0, '0, 1, 0, 0);
    tick(0, 2'd0, '0, 1, 0, 0);
    tick(1, 2'd1, mk(32'h0, 32'h9999_0000, 32'h0), 0, 0, 0);
    tick(1, 2'd2, mk(32'h0, 32'h0, 32'h8888_0000), 0, 0, 0);
    tick(1, 2'd0, mk(32'h7777_0000, 32'h0, 32'h0), 0, 0, 1);
    tick(0, 2'd0, '0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_pipe_muxn_reg
